// File: rtl/edge_detector_sync_pkg.sv
// ---------------------------------------------------------------------------
// edge_detector_sync_pkg : edge-mode codes, repeat FSM states, sizing helper
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package edge_detector_sync_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int tmr_width(input int hold_cycles, input int repeat_cycles);
        return $clog2(((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detector_sync_if.sv
// ---------------------------------------------------------------------------
// edge_detector_sync_if : raw inputs and conditioned level/pulse outputs
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface edge_detector_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] signal_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic [WIDTH-1:0] edge_detect_pulse;

    modport master (
        output signal_in,
        input  level_out, rise_pulse, fall_pulse, repeat_pulse, edge_detect_pulse
    );

    modport slave (
        input  signal_in,
        output level_out, rise_pulse, fall_pulse, repeat_pulse, edge_detect_pulse
    );
endinterface

`default_nettype wire

// File: rtl/edge_detector_sync_channel.sv
// ---------------------------------------------------------------------------
// edge_detector_sync_channel : one channel - sync, debounce, edge pulses, repeat FSM
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_detector_sync_channel
    import edge_detector_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 500000,
    parameter int REPEAT_CYCLES   = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = tmr_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [TMR_W-1:0]       r_tmr;
    rpt_state_e             r_state;
    logic                   w_s;
    logic                   w_accept;
    logic                   w_acc_rise;
    logic                   w_acc_fall;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_accept   = (w_s != level_out) && (r_cnt == C_DEB_LAST);
    assign w_acc_rise = w_accept &  w_s;
    assign w_acc_fall = w_accept & ~w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
    end

    // Debounce counter only runs while the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= w_acc_rise;
            fall_pulse <= w_acc_fall;
            if (w_s == level_out) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                level_out <= w_s;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // An accepted fall overrides everything, including a repeat expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tmr        <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (w_acc_fall) begin
                r_state <= ST_IDLE;
                r_tmr   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_acc_rise) begin
                            r_state <= ST_HOLD;
                            r_tmr   <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (r_tmr == C_HOLD_LAST) begin
                            r_state      <= ST_REPEAT;
                            r_tmr        <= '0;
                            repeat_pulse <= (REPEAT_EN != 0);
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_tmr == C_REP_LAST) begin
                            r_tmr        <= '0;
                            repeat_pulse <= (REPEAT_EN != 0);
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tmr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/edge_detector_sync.sv
// ---------------------------------------------------------------------------
// edge_detector_sync : multi-channel button conditioner with edge/repeat pulse bus
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_detector_sync
    import edge_detector_sync_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 500000,
    parameter int REPEAT_CYCLES   = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    edge_detector_sync_if.slave  bus
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_params
        $error("edge_detector_sync: illegal parameter combination");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_detector_sync_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .signal_in    (bus.signal_in[i]),
            .level_out    (bus.level_out[i]),
            .rise_pulse   (bus.rise_pulse[i]),
            .fall_pulse   (bus.fall_pulse[i]),
            .repeat_pulse (bus.repeat_pulse[i])
        );
    end

    logic [WIDTH-1:0] w_edges;

    if (EDGE_MODE == EDGE_RISE) begin : g_rise
        assign w_edges = bus.rise_pulse;
    end else if (EDGE_MODE == EDGE_FALL) begin : g_fall
        assign w_edges = bus.fall_pulse;
    end else begin : g_both
        assign w_edges = bus.rise_pulse | bus.fall_pulse;
    end

    // repeat_pulse is already held at zero inside each channel when repeat is disabled.
    assign bus.edge_detect_pulse = w_edges | bus.repeat_pulse;

endmodule

`default_nettype wire

// File: tb/tb_edge_detector_sync.sv
// ---------------------------------------------------------------------------
// tb_edge_detector_sync : directed checks on two configurations of edge_detector_sync
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_edge_detector_sync;
    import edge_detector_sync_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    edge_detector_sync_if #(.WIDTH(4)) ifa ();
    edge_detector_sync_if #(.WIDTH(4)) ifb ();

    edge_detector_sync #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_BOTH),
        .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );

    edge_detector_sync #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(EDGE_FALL),
        .REPEAT_EN(0), .HOLD_CYCLES(3), .REPEAT_CYCLES(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        logic [3:0] acc;
        rst_n         = 1'b0;
        ifa.signal_in = 4'b0000;
        ifb.signal_in = 4'b0000;
        tick(3);
        chk("rst_a_level", ifa.level_out, 4'b0000);
        chk("rst_a_pulses", ifa.rise_pulse | ifa.fall_pulse | ifa.repeat_pulse | ifa.edge_detect_pulse, 4'b0000);
        chk("rst_b_all", ifb.level_out | ifb.rise_pulse | ifb.fall_pulse | ifb.edge_detect_pulse, 4'b0000);
        rst_n = 1'b1;
        tick(3);

        // ch0 rise with DEB=4: visible after edge 5
        ifa.signal_in = 4'b0001;
        tick(5);
        chk("t1_level_early", ifa.level_out, 4'b0000);
        chk("t1_rise_early", ifa.rise_pulse, 4'b0000);
        tick(1);
        chk("t1_level", ifa.level_out, 4'b0001);
        chk("t1_rise", ifa.rise_pulse, 4'b0001);
        chk("t1_edge", ifa.edge_detect_pulse, 4'b0001);
        tick(1);
        chk("t1_rise_one_cycle", ifa.rise_pulse, 4'b0000);
        chk("t1_level_held", ifa.level_out, 4'b0001);

        // repeat at rise+10, then every 4
        tick(8);
        chk("t4_no_rep_early", ifa.repeat_pulse, 4'b0000);
        tick(1);
        chk("t4_rep_first", ifa.repeat_pulse, 4'b0001);
        chk("t4_rep_edge", ifa.edge_detect_pulse, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick(3);
            chk("t4_rep_gap", ifa.repeat_pulse, 4'b0000);
            tick(1);
            chk("t4_rep_next", ifa.repeat_pulse, 4'b0001);
        end
        ifa.signal_in = 4'b0000;
        tick(4);
        chk("t4_rep_before_fall", ifa.repeat_pulse, 4'b0001);
        chk("t4_level_before_fall", ifa.level_out, 4'b0001);
        tick(2);
        chk("t4_level_fell", ifa.level_out, 4'b0000);
        chk("t4_fall", ifa.fall_pulse, 4'b0001);
        chk("t4_fall_edge", ifa.edge_detect_pulse, 4'b0001);
        chk("t4_rep_at_fall", ifa.repeat_pulse, 4'b0000);
        acc = 4'b0000;
        repeat (12) begin
            tick(1);
            acc |= ifa.repeat_pulse;
        end
        chk("t4_no_rep_after_fall", acc, 4'b0000);

        // 20-cycle pulse on ch1, both edges selected
        ifa.signal_in = 4'b0010;
        tick(6);
        chk("t3_rise_edge", ifa.edge_detect_pulse, 4'b0010);
        chk("t3_rise", ifa.rise_pulse, 4'b0010);
        tick(1);
        chk("t3_edge_gap", ifa.edge_detect_pulse, 4'b0000);
        tick(13);
        ifa.signal_in = 4'b0000;
        tick(6);
        chk("t3_fall_edge", ifa.edge_detect_pulse, 4'b0010);
        chk("t3_fall", ifa.fall_pulse, 4'b0010);
        tick(1);
        chk("t3_edge_after", ifa.edge_detect_pulse, 4'b0000);

        // 3-cycle glitch on ch2 is filtered
        ifa.signal_in = 4'b0100;
        tick(3);
        ifa.signal_in = 4'b0000;
        acc = 4'b0000;
        repeat (10) begin
            tick(1);
            acc |= ifa.level_out | ifa.rise_pulse | ifa.fall_pulse | ifa.edge_detect_pulse;
        end
        chk("t2_glitch_filtered", acc, 4'b0000);

        // ch0+ch3 together; ch0 fall lands on its second repeat expiry
        ifa.signal_in = 4'b1001;
        tick(6);
        chk("t6_rise_pair", ifa.rise_pulse, 4'b1001);
        chk("t6_edge_pair", ifa.edge_detect_pulse, 4'b1001);
        tick(8);
        ifa.signal_in = 4'b1000;
        tick(2);
        chk("t6_rep_pair", ifa.repeat_pulse, 4'b1001);
        tick(3);
        chk("t6_rep_gap", ifa.repeat_pulse, 4'b0000);
        tick(1);
        chk("t6_fall_wins", ifa.fall_pulse, 4'b0001);
        chk("t6_rep_suppressed", ifa.repeat_pulse, 4'b1000);
        ifa.signal_in = 4'b0000;
        tick(6);
        chk("t6_fall_ch3", ifa.fall_pulse, 4'b1000);
        tick(4);

        // async reset mid-HOLD with input held high
        ifa.signal_in = 4'b0001;
        tick(10);
        chk("t5_level_pre_rst", ifa.level_out, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t5_async_level", ifa.level_out, 4'b0000);
        chk("t5_async_pulses", ifa.rise_pulse | ifa.fall_pulse | ifa.repeat_pulse | ifa.edge_detect_pulse, 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("t5_level_early", ifa.level_out, 4'b0000);
        tick(1);
        chk("t5_rise_after_rst", ifa.rise_pulse, 4'b0001);
        tick(9);
        chk("t5_no_rep_early", ifa.repeat_pulse, 4'b0000);
        tick(1);
        chk("t5_rep_after_hold", ifa.repeat_pulse, 4'b0001);
        ifa.signal_in = 4'b0000;
        tick(8);

        // config B: DEB=1 latency 2, fall-only edges, repeat disabled
        ifb.signal_in = 4'b0101;
        tick(2);
        chk("b_level_early", ifb.level_out, 4'b0000);
        tick(1);
        chk("b_level", ifb.level_out, 4'b0101);
        chk("b_rise", ifb.rise_pulse, 4'b0101);
        chk("b_edge_no_rise", ifb.edge_detect_pulse, 4'b0000);
        acc = 4'b0000;
        repeat (10) begin
            tick(1);
            acc |= ifb.repeat_pulse | ifb.edge_detect_pulse;
        end
        chk("b_no_repeat", acc, 4'b0000);
        ifb.signal_in = 4'b0000;
        tick(2);
        chk("b_level_hold", ifb.level_out, 4'b0101);
        tick(1);
        chk("b_fall", ifb.fall_pulse, 4'b0101);
        chk("b_edge_fall", ifb.edge_detect_pulse, 4'b0101);
        chk("b_level_low", ifb.level_out, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
